// File: rtl/if_id_stage_pkg.sv
// Shared constants and types for the fetch/decode pipeline register.
package if_id_stage_pkg;

  localparam int unsigned W = 8;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_IMM = 4'hC;

  typedef enum logic [0:0] {
    S_OP  = 1'b0,
    S_IMM = 1'b1
  } if_id_state_t;

endpackage

// File: rtl/intr_edge_latch.sv
// Interrupt pin capture, rising-edge detect and sticky pending flag.
// IF_ID_INTR_SYNC_EN selects a two-flop synchronizer for an asynchronous pin.
module intr_edge_latch (
  input  logic clk,
  input  logic rst,
  input  logic intr_pin,
  input  logic int_clr,
  output logic intr
);

  logic pin_s;
  logic prev_q;
  logic intr_q;
  logic intr_d;
  logic rise;

`ifdef IF_ID_INTR_SYNC_EN
  logic sync1_q;
  logic sync2_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= intr_pin;
      sync2_q <= sync1_q;
    end
  end

  assign pin_s = sync2_q;
`else
  logic cap_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cap_q <= 1'b0;
    end else begin
      cap_q <= intr_pin;
    end
  end

  assign pin_s = cap_q;
`endif

  assign rise = pin_s & ~prev_q;

  // A new request wins over a simultaneous clear so nothing is lost.
  always_comb begin
    intr_d = rise | (intr_q & ~int_clr);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      prev_q <= 1'b0;
      intr_q <= 1'b0;
    end else begin
      prev_q <= pin_s;
      intr_q <= intr_d;
    end
  end

  assign intr = intr_q;

endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline register: captures fetched byte, PC+1 and sf1, assembles
// two-byte immediate instructions, and hosts the pending-interrupt latch.
module if_id_stage #(
  parameter int unsigned W          = if_id_stage_pkg::W,
  parameter logic [3:0]  IMM_OPCODE = if_id_stage_pkg::OP_IMM
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] instr_in,
  input  logic [W-1:0] pc_plus1_in,
  input  logic         sf1_in,
  input  logic         stall,
  input  logic         flush,
  input  logic         intr_pin,
  input  logic         int_clr,
  output logic [W-1:0] IR,
  output logic [W-1:0] imm,
  output logic [W-1:0] pc_plus1,
  output logic         reg_sf1,
  output logic         intr,
  output logic         valid
);

  import if_id_stage_pkg::*;

  localparam logic [W-1:0] NopInstr = {OP_NOP, {(W-4){1'b0}}};

  if_id_state_t state_q, state_d;

  logic [W-1:0] ir_q, ir_d;
  logic [W-1:0] imm_q, imm_d;
  logic [W-1:0] pc_q, pc_d;
  logic [W-1:0] op_hold_q, op_hold_d;
  logic         sf1_q, sf1_d;
  logic         valid_q, valid_d;
  logic         is_imm_op;

  // An sf1 byte is a pushed PC value, never an opcode.
  assign is_imm_op = (instr_in[W-1:W-4] == IMM_OPCODE) && !sf1_in;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_OP;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = S_OP;
    end else if (!stall) begin
      unique case (state_q)
        S_OP:    state_d = is_imm_op ? S_IMM : S_OP;
        S_IMM:   state_d = S_OP;
        default: state_d = S_OP;
      endcase
    end
  end

  always_comb begin
    ir_d      = ir_q;
    imm_d     = imm_q;
    pc_d      = pc_q;
    op_hold_d = op_hold_q;
    sf1_d     = sf1_q;
    valid_d   = valid_q;
    if (flush) begin
      ir_d    = NopInstr;
      valid_d = 1'b0;
      sf1_d   = 1'b0;
    end else if (!stall) begin
      unique case (state_q)
        S_OP: begin
          pc_d  = pc_plus1_in;
          sf1_d = sf1_in;
          if (is_imm_op) begin
            op_hold_d = instr_in;
            ir_d      = NopInstr;
            valid_d   = 1'b0;
          end else begin
            ir_d    = instr_in;
            valid_d = 1'b1;
          end
        end
        S_IMM: begin
          imm_d   = instr_in;
          ir_d    = op_hold_q;
          valid_d = 1'b1;
        end
        default: begin
          ir_d    = NopInstr;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ir_q      <= NopInstr;
      imm_q     <= '0;
      pc_q      <= '0;
      op_hold_q <= '0;
      sf1_q     <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      ir_q      <= ir_d;
      imm_q     <= imm_d;
      pc_q      <= pc_d;
      op_hold_q <= op_hold_d;
      sf1_q     <= sf1_d;
      valid_q   <= valid_d;
    end
  end

  intr_edge_latch u_intr_edge_latch (
    .clk      (clk),
    .rst      (rst),
    .intr_pin (intr_pin),
    .int_clr  (int_clr),
    .intr     (intr)
  );

  assign IR       = ir_q;
  assign imm      = imm_q;
  assign pc_plus1 = pc_q;
  assign reg_sf1  = sf1_q;
  assign valid    = valid_q;

endmodule

// File: tb/tb_if_id_stage.sv
// Directed-vector bench for if_id_stage with hand-computed expectations.
module tb_if_id_stage;

`ifdef IF_ID_INTR_SYNC_EN
  localparam int IntLat = 3;
`else
  localparam int IntLat = 2;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] instr_in;
  logic [7:0] pc_plus1_in;
  logic       sf1_in;
  logic       stall;
  logic       flush;
  logic       intr_pin;
  logic       int_clr;
  logic [7:0] IR;
  logic [7:0] imm;
  logic [7:0] pc_plus1;
  logic       reg_sf1;
  logic       intr;
  logic       valid;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  if_id_stage dut (
    .clk         (clk),
    .rst         (rst),
    .instr_in    (instr_in),
    .pc_plus1_in (pc_plus1_in),
    .sf1_in      (sf1_in),
    .stall       (stall),
    .flush       (flush),
    .intr_pin    (intr_pin),
    .int_clr     (int_clr),
    .IR          (IR),
    .imm         (imm),
    .pc_plus1    (pc_plus1),
    .reg_sf1     (reg_sf1),
    .intr        (intr),
    .valid       (valid)
  );

  // Advance one rising edge; outputs are sampled 1ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; instr_in = 8'h5A; pc_plus1_in = 8'h77; sf1_in = 1'b0;
    stall = 1'b0; flush = 1'b0; intr_pin = 1'b0; int_clr = 1'b0;
    step(); step();
    tests++; if (IR !== 8'h00) begin fails++; $display("FAIL reset_ir got %h exp 00", IR); end
    tests++; if (valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", valid); end
    tests++; if (intr !== 1'b0) begin fails++; $display("FAIL reset_intr got %b exp 0", intr); end
    tests++; if (imm !== 8'h00 || pc_plus1 !== 8'h00 || reg_sf1 !== 1'b0) begin
      fails++; $display("FAIL reset_regs got imm=%h pc=%h sf1=%b exp 00/00/0", imm, pc_plus1, reg_sf1);
    end
    rst = 1'b1; instr_in = 8'h21; pc_plus1_in = 8'h01;
    step();
    tests++; if (IR !== 8'h21 || valid !== 1'b1 || pc_plus1 !== 8'h01) begin
      fails++; $display("FAIL reset_release got IR=%h v=%b pc=%h exp 21/1/01", IR, valid, pc_plus1);
    end
  endtask

  task automatic test_two_byte();
    instr_in = 8'hC4; pc_plus1_in = 8'h10;
    step();
    tests++; if (valid !== 1'b0 || IR !== 8'h00 || pc_plus1 !== 8'h10) begin
      fails++; $display("FAIL two_byte_op got IR=%h v=%b pc=%h exp 00/0/10", IR, valid, pc_plus1);
    end
    instr_in = 8'h7F; pc_plus1_in = 8'h11;
    step();
    tests++; if (IR !== 8'hC4 || imm !== 8'h7F || valid !== 1'b1 || pc_plus1 !== 8'h10) begin
      fails++; $display("FAIL two_byte_imm got IR=%h imm=%h v=%b pc=%h exp C4/7F/1/10",
                        IR, imm, valid, pc_plus1);
    end
  endtask

  task automatic test_stall();
    instr_in = 8'hC4; pc_plus1_in = 8'h20;
    step();
    stall = 1'b1; instr_in = 8'h11; pc_plus1_in = 8'h21;
    for (int k = 0; k < 3; k++) begin
      step();
      tests++; if (IR !== 8'h00 || valid !== 1'b0 || imm !== 8'h7F || pc_plus1 !== 8'h20) begin
        fails++; $display("FAIL stall_hold got IR=%h v=%b imm=%h pc=%h exp 00/0/7F/20",
                          IR, valid, imm, pc_plus1);
      end
    end
    stall = 1'b0; instr_in = 8'h33; pc_plus1_in = 8'h22;
    step();
    tests++; if (IR !== 8'hC4 || imm !== 8'h33 || valid !== 1'b1 || pc_plus1 !== 8'h20) begin
      fails++; $display("FAIL stall_release got IR=%h imm=%h v=%b pc=%h exp C4/33/1/20",
                        IR, imm, valid, pc_plus1);
    end
  endtask

  task automatic test_flush();
    instr_in = 8'hC8; pc_plus1_in = 8'h30;
    step();
    flush = 1'b1; instr_in = 8'h55; pc_plus1_in = 8'h31;
    step();
    tests++; if (IR !== 8'h00 || valid !== 1'b0 || pc_plus1 !== 8'h30 || imm !== 8'h33) begin
      fails++; $display("FAIL flush got IR=%h v=%b pc=%h imm=%h exp 00/0/30/33",
                        IR, valid, pc_plus1, imm);
    end
    flush = 1'b0; instr_in = 8'h10; pc_plus1_in = 8'h32;
    step();
    tests++; if (IR !== 8'h10 || valid !== 1'b1 || pc_plus1 !== 8'h32) begin
      fails++; $display("FAIL flush_next got IR=%h v=%b pc=%h exp 10/1/32", IR, valid, pc_plus1);
    end
    // Flush wins over a simultaneous stall.
    flush = 1'b1; stall = 1'b1; instr_in = 8'h44;
    step();
    tests++; if (IR !== 8'h00 || valid !== 1'b0) begin
      fails++; $display("FAIL flush_stall got IR=%h v=%b exp 00/0", IR, valid);
    end
    flush = 1'b0; stall = 1'b0;
  endtask

  task automatic test_sf1();
    sf1_in = 1'b1; instr_in = 8'hC0; pc_plus1_in = 8'h40;
    step();
    tests++; if (IR !== 8'hC0 || reg_sf1 !== 1'b1 || valid !== 1'b1) begin
      fails++; $display("FAIL sf1_pass got IR=%h sf1=%b v=%b exp C0/1/1", IR, reg_sf1, valid);
    end
    sf1_in = 1'b0; instr_in = 8'h22; pc_plus1_in = 8'h41;
    step();
    tests++; if (IR !== 8'h22 || valid !== 1'b1 || reg_sf1 !== 1'b0) begin
      fails++; $display("FAIL sf1_no_imm got IR=%h v=%b sf1=%b exp 22/1/0", IR, valid, reg_sf1);
    end
  endtask

  task automatic test_reset_mid();
    instr_in = 8'hC4; pc_plus1_in = 8'h50;
    step();
    rst = 1'b0;
    step();
    tests++; if (IR !== 8'h00 || valid !== 1'b0 || pc_plus1 !== 8'h00) begin
      fails++; $display("FAIL reset_mid got IR=%h v=%b pc=%h exp 00/0/00", IR, valid, pc_plus1);
    end
    rst = 1'b1; instr_in = 8'h7F; pc_plus1_in = 8'h51;
    step();
    tests++; if (IR !== 8'h7F || valid !== 1'b1) begin
      fails++; $display("FAIL reset_mid_next got IR=%h v=%b exp 7F/1", IR, valid);
    end
  endtask

  task automatic test_intr();
    intr_pin = 1'b1;
    // Flush and stall must not disturb the latch.
    flush = 1'b1; stall = 1'b1;
    for (int k = 1; k <= IntLat; k++) begin
      step();
      intr_pin = 1'b0;
      tests++; if (intr !== (k == IntLat)) begin
        fails++; $display("FAIL intr_latency edge %0d got %b exp %b", k, intr, (k == IntLat));
      end
    end
    flush = 1'b0; stall = 1'b0;
    step(); step(); step();
    tests++; if (intr !== 1'b1) begin fails++; $display("FAIL intr_sticky got %b exp 1", intr); end
    // New rising edge lands on the same edge as int_clr.
    intr_pin = 1'b1;
    for (int k = 1; k <= IntLat; k++) begin
      if (k == IntLat) int_clr = 1'b1;
      step();
      intr_pin = 1'b0;
    end
    int_clr = 1'b0;
    tests++; if (intr !== 1'b1) begin fails++; $display("FAIL intr_set_clr got %b exp 1", intr); end
    step(); step(); step();
    int_clr = 1'b1;
    step();
    int_clr = 1'b0;
    tests++; if (intr !== 1'b0) begin fails++; $display("FAIL intr_clear got %b exp 0", intr); end
  endtask

  initial begin
    test_reset();
    test_two_byte();
    test_stall();
    test_flush();
    test_sf1();
    test_reset_mid();
    test_intr();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/if_id_stage.md
# if_id_stage

Fetch-to-decode pipeline register for the 8-bit processor. Captures the fetched instruction byte, PC+1 and the interrupt-service flag, and presents them to the control unit and decode stage as `IR`, `pc_plus1` and `reg_sf1`. It assembles two-byte instructions (opcode 4'hC group) into opcode plus immediate. It also registers the external interrupt pin into the pending-interrupt flag `intr` consumed by the fetch control logic.

## Interface
Parameters:
- `W`, 8, datapath/instruction width
- `IMM_OPCODE`, 4'hC, opcode whose next byte is an immediate

Ports:
- `clk`  in  1  clock, all state updates on rising edge
- `rst`  in  1  reset, synchronous, active-low
- `instr_in`  in  W  byte from instruction memory / PC mux
- `pc_plus1_in`  in  W  PC+1 of the fetched byte
- `sf1_in`  in  1  fetch-side sf1 (1 = byte is PC for interrupt push)
- `stall`  in  1  hold all pipeline state
- `flush`  in  1  branch_taken; squash the fetched byte
- `intr_pin`  in  1  raw external interrupt request
- `int_clr`  in  1  clear pending interrupt
- `IR`  out  W  instruction to decode/CU
- `imm`  out  W  immediate byte of two-byte instruction
- `pc_plus1`  out  W  registered PC+1
- `reg_sf1`  out  1  registered sf1
- `intr`  out  1  pending-interrupt flag
- `valid`  out  1  `IR`/`imm` form a complete instruction

## Operation
- Reset (`rst`=0 at edge): `IR`=8'h00 (NOP), `imm`=0, `pc_plus1`=0, `reg_sf1`=0, `intr`=0, `valid`=0, FSM=S_OP, synchronizer flops=0.
- Priority per edge: reset > flush > stall > normal capture.
- FSM has two states:
  - S_OP: capture `instr_in`, `pc_plus1_in`, `sf1_in`.
    - If `instr_in[7:4]`==IMM_OPCODE and `sf1_in`=0: hold the opcode internally, drive `IR`=NOP with `valid`=0, go to S_IMM.
    - Otherwise drive `IR`=`instr_in` with `valid`=1 and stay in S_OP.
  - S_IMM: capture `instr_in` into `imm`, drive `IR`=held opcode byte with `valid`=1, keep the `pc_plus1` of the opcode byte, go to S_OP.
- `sf1_in`=1 (interrupt PC push) always takes the single-byte path; the byte passes through as data.
- Stall: every register and the FSM hold their values; `valid` holds.
- Flush: `IR`=NOP, `valid`=0, `reg_sf1`=0, FSM→S_OP, any half-assembled opcode is dropped; `imm` and `pc_plus1` hold.
- Interrupt latch:
  - Rising edge of the synchronized `intr_pin` sets `intr`; `int_clr` clears it.
  - A set and `int_clr` in the same cycle leave `intr`=1, so no request is lost.
  - The latch is unaffected by stall and flush.

## Timing
- Single-byte instruction: `instr_in` at edge N appears on `IR` with `valid`=1 after edge N.
- Two-byte instruction: opcode at edge N, immediate at edge N+1. `IR`/`imm` are valid after edge N+1, and `valid`=0 for the cycle after edge N.
- A stall during S_IMM holds the state; the immediate is captured at the first unstalled edge.
- Interrupt pin to `intr`: 2 edges without the macro, 3 edges with it (edge detect adds one).
- A flush and a stall in the same cycle resolve as flush.
- A reset at any point, including mid two-byte, returns to the reset values at that edge.

## Configuration
- `IF_ID_INTR_SYNC_EN` defined: `intr_pin` passes through a two-flop synchronizer before edge detection (asynchronous pin).
- Not defined: one capture flop, then edge detection (pin is already synchronous to `clk`).

## Structure
- Shared package:
  - opcode constants `OP_NOP`=4'h0 and `OP_IMM`=4'hC
  - width constant `W`=8
  - FSM state typedef {S_OP, S_IMM}
- One sub-module, `intr_edge_latch`: synchronizer/capture, rising-edge detect and set/clear flag, with `int_clr` input and `intr` output.
- The pipeline registers and the FSM stay in `if_id_stage`.

## Test plan
- Reset: hold `rst`=0 for 2 cycles while `instr_in`=8'h5A → `IR`=8'h00, `valid`=0, `intr`=0; then release with `instr_in`=8'h21 → `IR`=8'h21, `valid`=1 after one edge.
- Two-byte: `instr_in`=8'hC4 then 8'h7F → first cycle `valid`=0; next `IR`=8'hC4, `imm`=8'h7F, `valid`=1, `pc_plus1` = value presented with 8'hC4.
- Stall: `stall`=1 for 3 cycles mid two-byte (after 8'hC4) with `instr_in`=8'h11 → outputs unchanged; on release, the byte 8'h33 presented becomes `imm`.
- Flush: `flush`=1 after opcode 8'hC8 → `IR`=8'h00, `valid`=0, FSM in S_OP; next byte 8'h10 is decoded as a single-byte instruction.
- Interrupt: pulse `intr_pin` for 1 cycle → `intr`=1 after 2 edges (3 with macro); assert `int_clr` together with a new pin edge → `intr` stays 1; `int_clr` alone → `intr`=0.
- sf1 path: `sf1_in`=1, `instr_in`=8'hC0 → `IR`=8'hC0, `reg_sf1`=1, `valid`=1, no S_IMM entry.
